// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// Module   : pll_lock_supervisor
// Purpose  : Sequences the EHXPLLL reset and holds the SoC reset until the PLL
//            is stably locked; optional retry limit via PLL_SUP_RETRY_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int GLITCH_CYCLES  = 4,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  localparam int c_MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int c_MAX_CNT = (c_MAX_A > STABLE_CYCLES) ? c_MAX_A : STABLE_CYCLES;
  localparam int c_CNT_W   = (c_MAX_CNT > 1) ? $clog2(c_MAX_CNT) : 1;
  localparam int c_GL_W    = $clog2(GLITCH_CYCLES + 1);

  localparam logic [c_CNT_W-1:0] c_PLL_LAST    = c_CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_GL_W-1:0]  c_GLITCH_LAST = c_GL_W'(GLITCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  // Elaboration-time sanity checks on the configuration.
  if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || GLITCH_CYCLES < 1) begin : g_bad_cycles
    $error("pll_lock_supervisor: cycle parameters must be >= 1");
  end
  if (MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_retries
    $error("pll_lock_supervisor: MAX_RETRIES must fit the 4-bit retry counter");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_GL_W-1:0]    r_glitch;
  logic                 r_pll_rst;
  logic                 r_sys_reset;
  logic                 r_ready;
  logic                 r_fail;
  logic [7:0]           r_lock_loss_count;
  logic                 w_lock_loss;
  logic                 w_fail_nxt;

`ifdef PLL_SUP_RETRY_LIMIT_EN
  logic [3:0]           r_retry;
`endif

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= locked;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == c_PLL_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (r_sync2) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
`ifdef PLL_SUP_RETRY_LIMIT_EN
          w_state_nxt = (r_retry == 4'(MAX_RETRIES)) ? S_FAIL : S_RESET_PLL;
`else
          w_state_nxt = S_RESET_PLL;
`endif
        end
      end
      S_STABLE: begin
        if (!r_sync2) w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == c_STABLE_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!r_sync2 && r_glitch == c_GLITCH_LAST) w_state_nxt = S_RESET_PLL;
      end
      S_FAIL: begin
`ifdef PLL_SUP_RETRY_LIMIT_EN
        w_state_nxt = S_FAIL;
`else
        w_state_nxt = S_RESET_PLL;
`endif
      end
      default: w_state_nxt = S_RESET_PLL;
    endcase
  end

  assign w_lock_loss = (r_state == S_RUN) && (w_state_nxt == S_RESET_PLL);

`ifdef PLL_SUP_RETRY_LIMIT_EN
  assign w_fail_nxt = (w_state_nxt == S_FAIL);
`else
  assign w_fail_nxt = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RESET_PLL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shared cycle counter, cleared on every state change; idle in RUN/FAIL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (r_state == S_RUN || r_state == S_FAIL) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_glitch <= '0;
    end else if (r_state == S_RUN && w_state_nxt == S_RUN && !r_sync2) begin
      r_glitch <= r_glitch + 1'b1;
    end else begin
      r_glitch <= '0;
    end
  end

`ifdef PLL_SUP_RETRY_LIMIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retry <= 4'd0;
    end else if (r_state == S_RUN) begin
      r_retry <= 4'd0;
    end else if (r_state == S_WAIT_LOCK && w_state_nxt == S_RESET_PLL) begin
      r_retry <= r_retry + 4'd1;
    end
  end
`endif

  // Outputs are decoded from the next state so they move with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pll_rst         <= 1'b1;
      r_sys_reset       <= 1'b1;
      r_ready           <= 1'b0;
      r_fail            <= 1'b0;
      r_lock_loss_count <= 8'd0;
    end else begin
      r_pll_rst   <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAIL);
      r_sys_reset <= (w_state_nxt != S_RUN);
      r_ready     <= (w_state_nxt == S_RUN);
      r_fail      <= w_fail_nxt;
      if (w_lock_loss && r_lock_loss_count != 8'hFF) begin
        r_lock_loss_count <= r_lock_loss_count + 8'd1;
      end
    end
  end

  assign pll_rst         = r_pll_rst;
  assign sys_reset       = r_sys_reset;
  assign ready           = r_ready;
  assign fail            = r_fail;
  assign lock_loss_count = r_lock_loss_count;
  assign state           = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
// Module   : tb_pll_lock_supervisor
// Purpose  : Directed vector bench for pll_lock_supervisor (honours
//            PLL_SUP_RETRY_LIMIT_EN for the timeout sequence).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_supervisor;

  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 20;
  localparam int STABLE_CYCLES  = 8;
  localparam int GLITCH_CYCLES  = 3;
  localparam int MAX_RETRIES    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       locked = 1'b0;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .GLITCH_CYCLES  (GLITCH_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .locked          (locked),
    .pll_rst         (pll_rst),
    .sys_reset       (sys_reset),
    .ready           (ready),
    .fail            (fail),
    .lock_loss_count (lock_loss_count),
    .state           (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lk;
    logic       p;
    logic       s;
    logic       r;
    logic [2:0] st;
    logic [7:0] llc;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input int n, input logic lk, input logic p, input logic s,
                              input logic r, input logic [2:0] st, input logic [7:0] llc);
    vec_t v;
    v.lk = lk; v.p = p; v.s = s; v.r = r; v.st = st; v.llc = llc;
    for (int k = 0; k < n; k++) vt.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return ready == 1'b1;
      1:       return state == 3'd0;
      default: return state == 3'd2;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int bound, input string name);
    int n;
    n = 0;
    while (!cond(sel) && n < bound) begin
      step();
      n++;
    end
    if (!cond(sel)) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out after %0d cycles, state=%0d", name, n, state);
    end
  endtask

  task automatic do_reset(input logic lk);
    reset  = 1'b1;
    locked = lk;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, state=%0d", state);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Power-up through release, first lock, short/long glitches, relock.
    add(3, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
    add(3, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 8'd0);
    add(2, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'd0);
    add(8, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'd0);
    add(2, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'd0);
    add(2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'd0);
    add(3, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'd0);
    add(3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'd0);
    add(1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'd0);
    add(4, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'd1);
    add(1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'd1);
    add(8, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'd1);
    add(1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'd1);

    #1 reset = 1'b1;
    #1;
    chk("reset_state", {28'd0, pll_rst, sys_reset, ready, fail}, 32'b1100);
    chk("reset_fsm", state, 0);
    chk("reset_llc", lock_loss_count, 0);

    do_reset(1'b0);
    for (int i = 0; i < vt.size(); i++) begin
      locked = vt[i].lk;
      step();
      n_vec++;
      if ({pll_rst, sys_reset, ready, fail, state, lock_loss_count} !==
          {vt[i].p, vt[i].s, vt[i].r, 1'b0, vt[i].st, vt[i].llc}) begin
        n_err++;
        $display("FAIL vec%0d: pll_rst/sys_reset/ready/fail/state/llc got %b/%b/%b/%b/%0d/%0d expected %b/%b/%b/0/%0d/%0d",
                 i, pll_rst, sys_reset, ready, fail, state, lock_loss_count,
                 vt[i].p, vt[i].s, vt[i].r, vt[i].st, vt[i].llc);
      end
    end

    // Lock never arrives: timeout/retry cadence.
    do_reset(1'b0);
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (pll_rst && n < 50) begin step(); n++; end
      chk("timeout_pll_rst_width", n, PLL_RST_CYCLES);
      chk("timeout_wait_state", state, 1);
      n = 0;
      while (state == 3'd1 && n < 100) begin step(); n++; end
      chk("timeout_wait_width", n, LOCK_TIMEOUT);
    end
`ifdef PLL_SUP_RETRY_LIMIT_EN
    chk("retry_fail_state", state, 4);
    chk("retry_fail_flag", fail, 1);
    locked = 1'b1;
    repeat (30) step();
    chk("fail_sticky_state", state, 4);
    chk("fail_sticky_outputs", {29'd0, pll_rst, sys_reset, ready}, 32'b110);
`else
    chk("retry_forever_state", state, 0);
    chk("retry_forever_fail", fail, 0);
    chk("retry_forever_pll_rst", pll_rst, 1);
`endif

    // Single-cycle dropout during STABLE at cnt=5 restarts the window.
    do_reset(1'b1);
    wait_cond(2, 30, "stable_entry");
    repeat (3) step();
    locked = 1'b0;
    step();
    locked = 1'b1;
    step();
    chk("stable_cnt5_state", state, 2);
    step();
    chk("stable_drop_to_wait", state, 1);
    step();
    chk("stable_reentry", state, 2);
    n = 0;
    while (state == 3'd2 && sys_reset && n < 20) begin step(); n++; end
    chk("stable_fresh_window", n, STABLE_CYCLES);
    chk("stable_run_state", state, 3);
    chk("stable_sys_reset_low", sys_reset, 0);

    // Asynchronous reset between clock edges while in RUN.
    #3 reset = 1'b1;
    #1;
    chk("async_reset_outputs", {29'd0, pll_rst, sys_reset, ready}, 32'b110);
    chk("async_reset_state", state, 0);

    // Repeated lock losses saturate the loss counter.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      wait_cond(0, 60, "sat_wait_ready");
      locked = 1'b0;
      wait_cond(1, 12, "sat_wait_loss");
      if (i == 0) chk("llc_first_loss", lock_loss_count, 1);
      if (i == 254) chk("llc_reach_255", lock_loss_count, 255);
    end
    chk("llc_saturated", lock_loss_count, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Consumes the `locked` output of the main EHXPLLL and generates the SoC reset, holding it until the PLL is stably locked.
- Drives the PLL RST input.
- Retries lock acquisition on timeout.
- Filters short lock dropouts.
- Re-sequences the whole clock/reset chain on a genuine lock loss.

Clocked from the 50 MHz board reference clock, never from a PLL output, so it keeps running while the PLL is unlocked.

Parameters:
- PLL_RST_CYCLES, 16, cycles `pll_rst` is held high per PLL reset attempt (>=1).
- LOCK_TIMEOUT, 50000, cycles in WAIT_LOCK without lock before a retry (>=1; 1 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive locked cycles required before releasing `sys_reset` (>=1).
- GLITCH_CYCLES, 4, consecutive unlocked samples in RUN that count as lock loss (>=1).
- MAX_RETRIES, 3, timeouts tolerated before FAIL (used only with the optional feature).

Ports:
- clk  in  1  50 MHz reference clock
- reset  in  1  asynchronous, active-high reset
- locked  in  1  PLL LOCK output; asynchronous to `clk`
- pll_rst  out  1  PLL RST input drive, active high
- sys_reset  out  1  system reset, active high, synchronous deassertion
- ready  out  1  high only in RUN
- fail  out  1  sticky lock-failure flag
- lock_loss_count  out  8  saturating count of lock losses in RUN
- state  out  3  encoded FSM state, for debug

Behaviour:
- Reset (async, active high) forces:
  - state=RESET_PLL, `pll_rst`=1, `sys_reset`=1, `ready`=0, `fail`=0, `lock_loss_count`=0.
  - All internal counters 0 and both synchronizer flops 0.
- `locked` passes through a 2-flop synchronizer; `locked_sync` is the second flop.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- State encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- A single shared cycle counter `cnt` (width clog2 of the largest parameter) is cleared on every state entry.
- Glitch counter width is clog2(GLITCH_CYCLES+1).
- RESET_PLL:
  - `pll_rst`=1, `sys_reset`=1.
  - Exits to WAIT_LOCK at the edge where `cnt`==PLL_RST_CYCLES-1.
  - `pll_rst` is therefore high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - `pll_rst`=0, `sys_reset`=1.
  - `locked_sync`=1 -> STABLE.
  - Otherwise, at `cnt`==LOCK_TIMEOUT-1 -> RESET_PLL and the retry counter increments.
  - If both conditions hold on the same edge, lock wins.
- STABLE:
  - `locked_sync`=0 -> WAIT_LOCK; no retry increment; the timeout restarts.
  - At `cnt`==STABLE_CYCLES-1 with `locked_sync`=1 -> RUN.
  - `sys_reset` therefore falls STABLE_CYCLES+2 edges after the edge that first samples `locked`=1.
- RUN:
  - `sys_reset`=0, `ready`=1; the retry counter is cleared.
  - The glitch counter increments on each edge with `locked_sync`=0 and clears on any `locked_sync`=1.
  - On the edge where it reaches GLITCH_CYCLES -> RESET_PLL, with `sys_reset`=1 and `ready`=0 on that same edge.
  - On that edge `lock_loss_count` increments, saturating at 255.
- FAIL: only reachable with the optional feature.
- Reset asserted mid-operation returns to the reset values immediately, independent of `clk`; sequencing restarts from RESET_PLL.
- `sys_reset` never deasserts unless the state is RUN.

Optional Feature:
- Macro: PLL_SUP_RETRY_LIMIT_EN.
- Defined:
  - A 4-bit retry counter is kept.
  - A timeout that occurs when retries==MAX_RETRIES goes to FAIL instead of RESET_PLL.
  - FAIL: `pll_rst`=1, `sys_reset`=1, `ready`=0, `fail`=1. It is sticky; only the `reset` port exits it.
- Undefined:
  - No retry counter; timeouts always go to RESET_PLL and retry forever.
  - FAIL is unreachable and `fail` is tied to 0.

Test Plan:
Common parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, GLITCH_CYCLES=3, MAX_RETRIES=2.
1. Release `reset` with `locked`=0 -> `pll_rst` high exactly 4 cycles, then low; `sys_reset`=1; `state`=1.
2. Raise `locked` and hold it -> `sys_reset` falls and `ready` rises exactly 10 edges after the first sampling edge; `state`=3; `lock_loss_count`=0.
3. In RUN, pulse `locked` low for 2 cycles -> `sys_reset` stays 0 and `lock_loss_count` stays 0. A 3-cycle low pulse -> `sys_reset`=1, `state`=0, `pll_rst` high 4 cycles, `lock_loss_count`=1.
4. Hold `locked`=0 from reset -> WAIT_LOCK lasts 20 cycles, then `pll_rst` re-pulses for 4 cycles, repeating. With PLL_SUP_RETRY_LIMIT_EN, the 3rd timeout gives `fail`=1, `state`=4, held until `reset`.
5. In STABLE, drop `locked` for 1 cycle at `cnt`=5 -> returns to WAIT_LOCK with no retry counted; `sys_reset` is released only after a fresh full 8-cycle stable window.
6. Assert `reset` asynchronously mid-RUN, between clock edges -> `sys_reset`=1, `ready`=0, `pll_rst`=1 immediately. Force 300 lock losses -> `lock_loss_count` saturates at 255.
